if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of decode.
- Owns the PC and issues requests to instruction memory over a req/ack handshake that tolerates variable latency.
- Presents {pc+4, instruction, valid} to ID.
- Honours a load-use stall and a branch flush/redirect from ID.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0).
- NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on reset, bubble or flush.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin fetching; sampled only in IDLE.
- stall_i  in  1  hazard stall from ID; IF/ID and PC hold.
- flush_i  in  1  branch taken in ID; squash IF/ID and redirect.
- branch_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address; word aligned.
- imem_ack_i  in  1  data valid this cycle for the outstanding request.
- imem_data_i  in  32  fetched instruction.
- pc_o  out  32  IF/ID: address of fetched instruction + 4.
- instr_o  out  32  IF/ID: instruction.
- valid_o  out  1  IF/ID holds a real instruction.
- busy_o  out  1  request outstanding and not yet acked.

Behaviour:
- Reset (rst_i=0, async, immediate):
  - pc=PC_RESET, state=IDLE.
  - imem_req_o=0, imem_addr_o=PC_RESET.
  - pc_o=0, instr_o=NOP_INSTR, valid_o=0, busy_o=0, discard flag=0, hold buffer=0.
  - An outstanding request is abandoned.
- States: IDLE, FETCH, HOLD, DISCARD.
- IDLE:
  - imem_req_o=0.
  - start_i=1 -> FETCH next cycle.
  - flush_i and stall_i are ignored.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc. Address is stable until ack.
  - busy_o = imem_req_o & ~imem_ack_i.
  - ack & ~stall & ~flush: IF/ID <= {pc+4, imem_data_i, 1}; pc <= pc+4; stay in FETCH. The next request is issued the following cycle, so back-to-back acks give 1 instruction/cycle.
  - ack & stall & ~flush: data goes into the hold buffer; IF/ID unchanged; -> HOLD.
  - ~ack & ~stall & ~flush: IF/ID <= bubble {pc_o unchanged, NOP_INSTR, 0}.
  - ~ack & stall: IF/ID holds.
- HOLD:
  - imem_req_o=0. IF/ID holds while stall_i=1.
  - stall_i=0: IF/ID <= {pc+4, buffer, 1}; pc <= pc+4; -> FETCH.
- Flush (priority over stall and ack):
  - IF/ID <= bubble and pc <= {branch_pc_i[31:2],2'b00} in all cases.
  - In FETCH with ack the same cycle: data dropped; -> FETCH (new address next cycle).
  - In FETCH without ack: -> DISCARD.
  - In HOLD: buffer dropped; -> FETCH.
- DISCARD:
  - imem_req_o stays 1 with the OLD address (the handshake is never withdrawn). The old address is kept in an address register, separate from pc.
  - On ack: data dropped; -> FETCH at the new pc.
  - A further flush_i in DISCARD updates pc only.
  - IF/ID stays bubble unless stall_i=1, which holds it.
- Arithmetic:
  - pc+4 wraps modulo 2^32: 0xFFFF_FFFC -> 0x0000_0000.
  - pc_o = fetched address + 4, with the same wrap.
- valid_o is registered and changes only with the IF/ID update.

Test Plan:
- Reset, start_i pulse, ack every cycle with data 0x1000_0001.. -> addresses 0x0,0x4,0x8 on consecutive cycles; pc_o=0x4,0x8,0xC with valid_o=1 one cycle after each ack.
- Ack latency 3 cycles, no stall -> busy_o=1 for 3 cycles; IF/ID shows bubble (valid_o=0, instr_o=0) between instructions; imem_addr_o stable during the wait.
- stall_i=1 on the cycle ack returns 0xDEAD_BEEF at addr 0x8, stall held 4 cycles -> IF/ID unchanged, imem_req_o=0. After release, instr_o=0xDEAD_BEEF, pc_o=0xC, next request to 0xC.
- flush_i with branch_pc_i=0x0000_0103 while a request to 0x10 is outstanding -> imem_addr_o stays 0x10 until ack; that data is dropped; next request to 0x100; valid_o=0 throughout.
- flush_i and stall_i together with ack present -> IF/ID becomes bubble, data dropped, next address = branch target.
- PC_RESET=0xFFFF_FFFC -> first pc_o=0x0, second address 0x0. Assert rst_i=0 mid-request -> imem_req_o=0 and valid_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register. Drives a variable-latency
// req/ack instruction memory and supports load-use stall and branch flush/redirect.
module if_stage #(
   parameter logic [31:0] PC_RESET  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] branch_pc_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] pc_o,
   output logic [31:0] instr_o,
   output logic        valid_o,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_HOLD,
      S_DISCARD
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] addr_q, addr_d;     // address of the abandoned request while discarding
   logic [31:0] buf_q, buf_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic        if_valid_q, if_valid_d;

   logic [31:0] pc_plus4;
   logic [31:0] target;

   assign pc_plus4 = pc_q + 32'd4;
   assign target   = branch_pc_i & ~32'h0000_0003;

   // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      addr_d     = addr_q;
      buf_d      = buf_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if_valid_d = if_valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_FETCH;
         end

         S_FETCH: begin
            if (flush_i) begin
               if_instr_d = NOP_INSTR;
               if_valid_d = 1'b0;
               pc_d       = target;
               if (!imem_ack_i) begin
                  addr_d  = pc_q;
                  state_d = S_DISCARD;
               end
            end else if (imem_ack_i && !stall_i) begin
               if_pc_d    = pc_plus4;
               if_instr_d = imem_data_i;
               if_valid_d = 1'b1;
               pc_d       = pc_plus4;
            end else if (imem_ack_i) begin
               buf_d   = imem_data_i;
               state_d = S_HOLD;
            end else if (!stall_i) begin
               if_instr_d = NOP_INSTR;
               if_valid_d = 1'b0;
            end
         end

         S_HOLD: begin
            if (flush_i) begin
               if_instr_d = NOP_INSTR;
               if_valid_d = 1'b0;
               pc_d       = target;
               state_d    = S_FETCH;
            end else if (!stall_i) begin
               if_pc_d    = pc_plus4;
               if_instr_d = buf_q;
               if_valid_d = 1'b1;
               pc_d       = pc_plus4;
               state_d    = S_FETCH;
            end
         end

         S_DISCARD: begin
            // The old request must complete; its data is thrown away.
            if (flush_i) pc_d = target;
            if (imem_ack_i) state_d = S_FETCH;
            if (flush_i || !stall_i) begin
               if_instr_d = NOP_INSTR;
               if_valid_d = 1'b0;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= S_IDLE;
         pc_q       <= PC_RESET;
         addr_q     <= PC_RESET;
         buf_q      <= 32'h0;
         if_pc_q    <= 32'h0;
         if_instr_q <= NOP_INSTR;
         if_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         addr_q     <= addr_d;
         buf_q      <= buf_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
         if_valid_q <= if_valid_d;
      end
   end

   assign imem_req_o  = (state_q == S_FETCH) || (state_q == S_DISCARD);
   assign imem_addr_o = (state_q == S_DISCARD) ? addr_q : pc_q;
   assign busy_o      = imem_req_o & ~imem_ack_i;
   assign pc_o        = if_pc_q;
   assign instr_o     = if_instr_q;
   assign valid_o     = if_valid_q;

endmodule
